// File: rtl/tx_pkg.sv
// Shared types and constants for the display UART transmitter.
// FSM states, CPU address map, status bit positions, ASCII codes.
package tx_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int BIT_BUSY = 7;
    localparam int BIT_IDLE = 6;
    localparam int BIT_OVF  = 0;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_display_tx_fifo.sv
// Small first-word-fall-through FIFO for the display transmitter.
// Ports: clk, rst_n, push/din, pop/dout, full, empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // Fullness is sampled before any pop in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_display_tx.sv
// CPU display port: FIFO-buffered 8N1 UART transmitter with busy bit.
// Ports: clk, rst_n, cs/we/address/din/dout CPU bus, uart_tx, led_activity.
module uart_display_tx
    import tx_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4,
    parameter int CRLF       = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs,
    input  logic       we,
    input  logic       address,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       uart_tx,
    output logic       led_activity
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    tx_state_t  state;
    logic [CW-1:0] bit_cnt;
    logic [2:0] bit_idx;
    logic [7:0] tx_byte;
    logic       pending_lf;
    logic       led_tog;
    logic       overflow;

    logic       push;
    logic       pop;
    logic [7:0] wdata;
    logic [7:0] fifo_dout;
    logic       full;
    logic       empty;
    logic       rd_en;
    logic       rd_status;
    logic       tx_idle;
    logic [7:0] rd_word;

    assign push      = cs && we && (address == ADDR_DATA);
    assign wdata     = din & 8'h7F;
    assign rd_en     = cs && !we;
    assign rd_status = rd_en && (address == ADDR_STATUS);
    // A pending LF wins over the FIFO, so no pop while one is owed.
    assign pop       = (state == S_IDLE) && !pending_lf && !empty;
    assign tx_idle   = empty && (state == S_IDLE) && !pending_lf;
    assign led_activity = ~led_tog;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (wdata),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        rd_word = '0;
        rd_word[BIT_BUSY] = full;
        if (address == ADDR_STATUS) begin
            rd_word[BIT_IDLE] = tx_idle;
            rd_word[BIT_OVF]  = overflow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= 8'h00;
            overflow <= 1'b0;
        end else begin
            if (rd_en) begin
                dout <= rd_word;
            end
            // A fresh overflow beats the clear-on-read.
            overflow <= (push && full) || (overflow && !rd_status);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            tx_byte    <= '0;
            pending_lf <= 1'b0;
            led_tog    <= 1'b0;
            uart_tx    <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    if (pending_lf) begin
                        tx_byte    <= ASCII_LF;
                        pending_lf <= 1'b0;
                        state      <= S_START;
                        uart_tx    <= 1'b0;
                    end else if (!empty) begin
                        tx_byte <= fifo_dout;
                        state   <= S_START;
                        uart_tx <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_cnt == LAST) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= S_DATA;
                        uart_tx <= tx_byte[0];
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_cnt == LAST) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state   <= S_STOP;
                            uart_tx <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            uart_tx <= tx_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_cnt == LAST) begin
                        bit_cnt <= '0;
                        state   <= S_IDLE;
                        led_tog <= ~led_tog;
                        if (CRLF == 1 && tx_byte == ASCII_CR) begin
                            pending_lf <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
